// File: rtl/mips_multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// opcode/funct values, ALU control codes and ALU operand-B selects.
package mips_multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  // ALU operation class handed from the FSM to the ALU decoder
  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;

endpackage

// File: rtl/mips_multicycle_controller_alu_decoder.sv
// ALU decoder: maps the FSM's operation class plus the R-type funct field
// to an ALUControl code; flags funct values the ALU cannot execute.
module mips_alu_decoder
  import mips_multicycle_controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_illegal
);

  // Unknown functs fall back to add so the writeback still has a defined result
  always_comb begin
    alu_control   = ALU_ADD;
    funct_illegal = 1'b0;
    case (aluop)
      AOP_SUB:   alu_control = ALU_SUB;
      AOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      default:   alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore multicycle control unit for the shared-memory MIPS datapath.
// One state per cycle; outputs decode from the current state (PCEn in
// BRANCH also follows zero). Write enables are masked while rst is high.
module mips_multicycle_controller
  import mips_multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCEn,
  output logic       IorD,
  output logic       Memwrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic [2:0] ALUControl,
  output logic       PCsrc,
  output logic [3:0] state_dbg,
  output logic       illegal_op
);

  state_t     state_q, state_d, dec_state;
  logic       illegal_q, illegal_d;
  logic [1:0] aluop;
  logic       alu_used;
  logic [2:0] alu_ctrl;
  logic       funct_illegal;
  logic       pcen_raw, memwrite_raw, irwrite_raw, regwrite_raw;

  mips_alu_decoder u_alu_dec (
    .aluop         (aluop),
    .funct         (funct),
    .alu_control   (alu_ctrl),
    .funct_illegal (funct_illegal)
  );

  // State and sticky illegal flag registers
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    illegal_q <= illegal_d;
  end

  // Next-state and output decode; reset decodes as FETCH
  always_comb begin
    state_d      = S_FETCH;
    illegal_d    = illegal_q;
    dec_state    = rst ? S_FETCH : state_q;
    aluop        = AOP_ADD;
    alu_used     = 1'b0;
    pcen_raw     = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    IorD         = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    ALUsrcA      = 1'b0;
    ALUsrcB      = SRCB_REG;
    PCsrc        = 1'b0;
    case (dec_state)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        ALUsrcB     = SRCB_ONE;
        alu_used    = 1'b1;
        pcen_raw    = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        // Word-addressed memory: branch target is PC+1+SignImm, no shift
        ALUsrcB  = SRCB_IMM;
        alu_used = 1'b1;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUsrcA  = 1'b1;
        ALUsrcB  = SRCB_IMM;
        alu_used = 1'b1;
        state_d  = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_MEMWRITE: begin
        IorD         = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_EXECUTE: begin
        ALUsrcA  = 1'b1;
        aluop    = AOP_FUNCT;
        alu_used = 1'b1;
        state_d  = S_ALUWB;
        if (funct_illegal) illegal_d = 1'b1;
      end
      S_ALUWB: begin
        RegDst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_BRANCH: begin
        ALUsrcA  = 1'b1;
        aluop    = AOP_SUB;
        alu_used = 1'b1;
        PCsrc    = 1'b1;
        pcen_raw = zero;
      end
      S_ADDIEX: begin
        ALUsrcA  = 1'b1;
        ALUsrcB  = SRCB_IMM;
        alu_used = 1'b1;
        state_d  = S_ADDIWB;
      end
      S_ADDIWB: regwrite_raw = 1'b1;
      default:  state_d = S_FETCH;
    endcase
    if (rst) begin
      state_d   = S_FETCH;
      illegal_d = 1'b0;
    end
  end

  assign ALUControl = alu_used ? alu_ctrl : 3'b000;
  assign PCEn       = pcen_raw & ~rst;
  assign Memwrite   = memwrite_raw & ~rst;
  assign IRWrite    = irwrite_raw & ~rst;
  assign RegWrite   = regwrite_raw & ~rst;
  assign state_dbg  = state_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
module tb_mips_multicycle_controller;

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4,
                         MW = 4'd5, EX = 4'd6, AWB = 4'd7, BR = 4'd8,
                         AE = 4'd9, AIW = 4'd10;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, ADDI = 6'b001000, BAD = 6'b111111;
  localparam int WAIT_LIMIT = 500;

  typedef struct packed {
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluctrl;
    logic       pcsrc;
    logic [3:0] st;
    logic       ill;
  } out_t;

  typedef struct {
    logic       r;
    logic [5:0] op, fn;
    logic       z;
    out_t       exp;
    string      name;
  } vec_t;

  logic       clk, rst, zero;
  logic [5:0] opcode, funct;
  logic       PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA, PCsrc, illegal_op;
  logic [1:0] ALUsrcB;
  logic [2:0] ALUControl;
  logic [3:0] state_dbg;

  vec_t  tbl[$];
  out_t  sb[$];
  string sbn[$];
  int    checks, errors;
  logic  done;
  int    wait_cnt;

  mips_multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .PCEn(PCEn), .IorD(IorD), .Memwrite(Memwrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ALUControl(ALUControl),
    .PCsrc(PCsrc), .state_dbg(state_dbg), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    done = 1'b0;
    wait_cnt = 0;
    while (!done && wait_cnt < WAIT_LIMIT) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (!done) begin
      errors++;
      $display("FAIL wait expired after %0d cycles", wait_cnt);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  function automatic out_t mk(input logic [3:0] st, input logic [2:0] alu,
                              input logic z, input logic ill, input logic r);
    out_t       o = '0;
    logic [3:0] d = r ? F : st;
    o.st  = st;
    o.ill = ill;
    case (d)
      F:   begin o.irwrite = 1; o.alusrcb = 2'b01; o.aluctrl = 3'b010; o.pcen = 1; end
      D:   begin o.alusrcb = 2'b10; o.aluctrl = 3'b010; end
      MA:  begin o.alusrca = 1; o.alusrcb = 2'b10; o.aluctrl = 3'b010; end
      MR:  o.iord = 1;
      MWB: begin o.memtoreg = 1; o.regwrite = 1; end
      MW:  begin o.iord = 1; o.memwrite = 1; end
      EX:  begin o.alusrca = 1; o.aluctrl = alu; end
      AWB: begin o.regdst = 1; o.regwrite = 1; end
      BR:  begin o.alusrca = 1; o.aluctrl = 3'b110; o.pcsrc = 1; o.pcen = z; end
      AE:  begin o.alusrca = 1; o.alusrcb = 2'b10; o.aluctrl = 3'b010; end
      AIW: o.regwrite = 1;
      default: ;
    endcase
    if (r) begin o.pcen = 0; o.irwrite = 0; o.memwrite = 0; o.regwrite = 0; end
    return o;
  endfunction

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic [3:0] st, input logic [2:0] alu,
                     input logic ill, input string name);
    vec_t v;
    v.r = r; v.op = op; v.fn = fn; v.z = z;
    v.exp = mk(st, alu, z, ill, r);
    v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    logic [5:0] fns  [5];
    logic [2:0] alus [5];
    out_t g, e;
    string n;
    fns  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    alus = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    checks = 0; errors = 0;

    add(1, 0, 0, 0, F, 0, 0, "rst_hold");
    add(0, LW, 0, 0, F,   0, 0, "lw_fetch");
    add(0, LW, 0, 0, D,   0, 0, "lw_decode");
    add(0, LW, 0, 0, MA,  0, 0, "lw_memadr");
    add(0, LW, 0, 0, MR,  0, 0, "lw_memread");
    add(0, LW, 0, 0, MWB, 0, 0, "lw_memwb");
    add(0, SW, 0, 0, F,  0, 0, "sw_fetch");
    add(0, SW, 0, 0, D,  0, 0, "sw_decode");
    add(0, SW, 0, 0, MA, 0, 0, "sw_memadr");
    add(0, SW, 0, 0, MW, 0, 0, "sw_memwrite");
    for (int i = 0; i < 5; i++) begin
      add(0, RT, fns[i], 0, F,   0,       0, $sformatf("rt%0d_fetch", i));
      add(0, RT, fns[i], 0, D,   0,       0, $sformatf("rt%0d_decode", i));
      add(0, RT, fns[i], 0, EX,  alus[i], 0, $sformatf("rt%0d_execute", i));
      add(0, RT, fns[i], 0, AWB, 0,       0, $sformatf("rt%0d_aluwb", i));
    end
    for (int z = 1; z >= 0; z--) begin
      add(0, BEQ, 0, z[0], F,  0, 0, $sformatf("beq_z%0d_fetch", z));
      add(0, BEQ, 0, z[0], D,  0, 0, $sformatf("beq_z%0d_decode", z));
      add(0, BEQ, 0, z[0], BR, 0, 0, $sformatf("beq_z%0d_branch", z));
    end
    add(0, ADDI, 0, 0, F,   0, 0, "addi_fetch");
    add(0, ADDI, 0, 0, D,   0, 0, "addi_decode");
    add(0, ADDI, 0, 0, AE,  0, 0, "addi_ex");
    add(0, ADDI, 0, 0, AIW, 0, 0, "addi_wb");
    add(0, BAD,  0, 0, F,   0, 0, "ill_fetch");
    add(0, BAD,  0, 0, D,   0, 0, "ill_decode");
    add(0, ADDI, 0, 0, F,   0, 1, "sticky_fetch");
    add(0, ADDI, 0, 0, D,   0, 1, "sticky_decode");
    add(0, ADDI, 0, 0, AE,  0, 1, "sticky_ex");
    add(0, ADDI, 0, 0, AIW, 0, 1, "sticky_wb");
    add(0, LW, 0, 0, F,  0, 1, "rstmid_fetch");
    add(0, LW, 0, 0, D,  0, 1, "rstmid_decode");
    add(0, LW, 0, 0, MA, 0, 1, "rstmid_memadr");
    add(1, LW, 0, 0, MR, 0, 1, "rstmid_rst");
    add(0, RT, BAD, 0, F,   0,      0, "badfn_fetch");
    add(0, RT, BAD, 0, D,   0,      0, "badfn_decode");
    add(0, RT, BAD, 0, EX,  3'b010, 0, "badfn_execute");
    add(0, RT, BAD, 0, AWB, 0,      1, "badfn_aluwb");
    add(0, RT, BAD, 0, F,   0,      1, "badfn_next_fetch");

    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
    @(posedge clk); #1;

    checks++;
    if (state_dbg !== F || PCEn !== 1'b0 || IRWrite !== 1'b0 || Memwrite !== 1'b0 ||
        RegWrite !== 1'b0 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL reset_state st=%0d PCEn=%b IRWrite=%b Memwrite=%b RegWrite=%b ill=%b",
               state_dbg, PCEn, IRWrite, Memwrite, RegWrite, illegal_op);
    end

    foreach (tbl[i]) begin
      rst = tbl[i].r; opcode = tbl[i].op; funct = tbl[i].fn; zero = tbl[i].z;
      sb.push_back(tbl[i].exp);
      sbn.push_back(tbl[i].name);
      @(negedge clk);
      g = '{pcen: PCEn, iord: IorD, memwrite: Memwrite, irwrite: IRWrite,
            regdst: RegDst, memtoreg: MemtoReg, regwrite: RegWrite,
            alusrca: ALUsrcA, alusrcb: ALUsrcB, aluctrl: ALUControl,
            pcsrc: PCsrc, st: state_dbg, ill: illegal_op};
      e = sb.pop_front();
      n = sbn.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s got=%h exp=%h (st got %0d exp %0d, ill got %b exp %b)",
                 n, g, e, g.st, e.st, g.ill, e.ill);
      end
      @(posedge clk); #1;
    end

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
Moore-style multicycle control unit that sequences the 32-bit shared instruction/data-memory datapath. Decodes opcode/funct captured in the datapath instruction register and drives every datapath enable and mux select, one FSM state per cycle. Sits beside the datapath in the processor top level; the datapath additionally exports the ALU zero flag to this block.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word
OP_SW, 6'b101011, store word
OP_BEQ, 6'b000100, branch if equal
OP_ADDI, 6'b001000, add immediate

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
opcode  input  6  Instr[31:26] from datapath
funct  input  6  Instr[5:0] from datapath
zero  input  1  ALUResult == 0 (combinational, from datapath)
PCEn  output  1  PC load enable
IorD  output  1  memory address select: 0 PC, 1 ALUOut
Memwrite  output  1  data memory write enable
IRWrite  output  1  instruction register load
RegDst  output  1  write-register select: 1 rd, 0 rt
MemtoReg  output  1  write-data select: 1 Data, 0 ALUOut
RegWrite  output  1  register file write enable
ALUsrcA  output  1  0 PC, 1 A
ALUsrcB  output  2  00 B, 01 constant 1, 10 SignImm, 11 SignImm<<2
ALUControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
PCsrc  output  1  0 ALUResult, 1 ALUOut
state_dbg  output  4  current state encoding
illegal_op  output  1  sticky: unsupported opcode or funct seen

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high, ports named clk and rst.
- On rst sampled high: state <= FETCH, illegal_op <= 0. While rst is high, PCEn, IRWrite, Memwrite and RegWrite are forced to 0. All other outputs follow FETCH decode.
- Outputs are a pure function of state, except PCEn in BRANCH, which also depends on zero. Unlisted outputs are 0. Mux selects not listed are don't-care and driven 0.
- FETCH: IorD=0, IRWrite=1, ALUsrcA=0, ALUsrcB=01, ALUControl=add, PCsrc=0, PCEn=1. Next state DECODE.
- DECODE: ALUsrcA=0, ALUsrcB=10, ALUControl=add, so ALUOut = PC+1+SignImm. Memory is word addressed, so SignImm is not shifted.
  - lw/sw -> MEMADR; R-type -> EXECUTE; beq -> BRANCH; addi -> ADDIEX.
  - Any other opcode -> FETCH and set illegal_op.
- MEMADR: ALUsrcA=1, ALUsrcB=10, add. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: IorD=1. Next MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next FETCH.
- MEMWRITE: IorD=1, Memwrite=1. Next FETCH.
- EXECUTE: ALUsrcA=1, ALUsrcB=00, ALUControl from funct decode. Next ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next FETCH.
- BRANCH: ALUsrcA=1, ALUsrcB=00, sub, PCsrc=1, PCEn=zero. Next FETCH.
- ADDIEX: ALUsrcA=1, ALUsrcB=10, add. Next ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next FETCH.
- Instruction latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, illegal 2.
- Funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct gives ALUControl=add. In EXECUTE it sets illegal_op, while the writeback still occurs.
- illegal_op clears only on rst.
- Unreachable state encodings -> FETCH next cycle, with no write enable asserted.
- rst asserted mid-instruction: next state FETCH regardless of the current state, and no write occurs in the reset cycle.

Decomposition:
- Shared package: state encodings (4-bit localparams), opcode and funct constants, ALUControl codes, ALUsrcB codes.
- One sub-module: mips_alu_decoder, combinational (aluop[1:0], funct) -> ALUControl, plus a funct_illegal flag.
  - aluop 00 add, 01 sub, 10 funct-decoded.

Test Plan:
- Reset: hold rst high for 2 cycles -> state_dbg=FETCH, PCEn=IRWrite=Memwrite=RegWrite=0, illegal_op=0. First cycle after release -> PCEn=1, IRWrite=1.
- lw (opcode 100011) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 with MemtoReg=1, RegDst=0 only in cycle 5. Back to FETCH in cycle 6.
- sw (101011) -> Memwrite=1 with IorD=1 in cycle 4 only; RegWrite never asserted.
- R-type sweep, 5 functs -> ALUControl 010, 110, 000, 001, 111 in EXECUTE; ALUWB has RegDst=1, RegWrite=1.
- beq -> zero=1 gives PCEn=1, PCsrc=1 in cycle 3; zero=0 gives PCEn=0. Then FETCH.
- opcode 111111 -> DECODE then FETCH, illegal_op=1 and sticky. rst pulse during MEMREAD -> FETCH next cycle, no RegWrite, illegal_op=0.
